// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : risc_pkg
//  Brief    : Shared ISA constants, fetch FSM encoding and opcode helpers for
//             the 8-bit RISC pipeline.
//  Revision : 1.0
// ============================================================================
package risc_pkg;

  localparam logic [7:0] NOP             = 8'h00;
  localparam logic [7:0] RESET_VEC_ADDR  = 8'h00;
  localparam logic [7:0] INTR_VEC_ADDR   = 8'h01;
  localparam logic [3:0] TWO_BYTE_NIBBLE = 4'hC;

  typedef enum logic [1:0] {
    ST_RST_VEC = 2'd0,
    ST_FETCH   = 2'd1,
    ST_IMM     = 2'd2,
    ST_INT_VEC = 2'd3
  } fetch_state_t;

  // C-group opcodes carry a trailing immediate byte.
  function automatic logic is_two_byte(input logic [7:0] opcode);
    return (opcode[7:4] == TWO_BYTE_NIBBLE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_reg
//  Brief    : 24-bit IF/ID pipeline register; clear beats hold, hold beats load.
//  Revision : 1.0
// ============================================================================
module if_id_reg
  import risc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       hold,
  input  logic [7:0] d_instr,
  input  logic [7:0] d_imm,
  input  logic [7:0] d_pc,
  output logic [7:0] instr_id,
  output logic [7:0] immediate,
  output logic [7:0] pc_id
);

  logic [7:0] r_instr;
  logic [7:0] r_imm;
  logic [7:0] r_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr <= NOP;
      r_imm   <= 8'h00;
      r_pc    <= 8'h00;
    end else if (clear) begin
      r_instr <= NOP;
      r_imm   <= 8'h00;
      r_pc    <= 8'h00;
    end else if (!hold) begin
      r_instr <= d_instr;
      r_imm   <= d_imm;
      r_pc    <= d_pc;
    end
  end

  assign instr_id  = r_instr;
  assign immediate = r_imm;
  assign pc_id     = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Brief    : Instruction fetch: PC, vector loads, two-byte assembly, IF/ID.
//             Interrupt vectoring is built only when FETCH_INTR_EN is defined.
//  Revision : 1.0
// ============================================================================
module fetch_stage
  import risc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       stall_F,
  input  logic       stall_D,
  input  logic       flush_F,
  input  logic       branch_taken_ex,
  input  logic [7:0] branch_target,
  input  logic       intr_ack,
  input  logic [7:0] imem_data,
  output logic [7:0] imem_addr,
  output logic [7:0] instr_id,
  output logic [7:0] immediate,
  output logic [7:0] pc_id
);

  fetch_state_t r_state, w_state_nxt;
  logic [7:0]   r_pc, w_pc_nxt;
  logic [7:0]   r_hold, w_hold_nxt;
  logic [7:0]   w_pc_inc;
  logic         w_adv;
  logic         w_bubble;
  logic         w_intr_take;
  logic         w_ifid_clear;
  logic         w_ifid_hold;
  logic [7:0]   w_ifid_instr;
  logic [7:0]   w_ifid_imm;
  logic [7:0]   w_ifid_pc;

`ifdef FETCH_INTR_EN
  assign w_intr_take = intr_ack && (r_state == ST_FETCH);
`else
  logic w_intr_ack_unused;
  assign w_intr_ack_unused = intr_ack;
  assign w_intr_take       = 1'b0;
`endif

  assign w_pc_inc = r_pc + 8'd1;
  assign w_adv    = !stall_F && !flush_F;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RST_VEC;
      r_pc    <= 8'h00;
      r_hold  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_hold_nxt   = r_hold;
    w_bubble     = 1'b0;
    w_ifid_clear = flush_F;
    w_ifid_hold  = stall_D;
    w_ifid_instr = imem_data;
    w_ifid_imm   = 8'h00;
    w_ifid_pc    = w_pc_inc;

    case (r_state)
      ST_RST_VEC: imem_addr = RESET_VEC_ADDR;
      ST_INT_VEC: imem_addr = INTR_VEC_ADDR;
      default:    imem_addr = r_pc;
    endcase

    if (branch_taken_ex) begin
      w_pc_nxt     = branch_target;
      w_state_nxt  = ST_FETCH;
      w_ifid_clear = 1'b1;
      w_ifid_hold  = 1'b0;
    end else if (w_intr_take) begin
      // Hand decode the first unfetched address as the return PC.
      w_state_nxt  = ST_INT_VEC;
      w_ifid_clear = 1'b0;
      w_ifid_hold  = 1'b0;
      w_ifid_instr = NOP;
      w_ifid_pc    = r_pc;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (is_two_byte(imem_data)) begin
            w_bubble = 1'b1;
            if (w_adv) begin
              w_hold_nxt  = imem_data;
              w_state_nxt = ST_IMM;
            end
          end
          if (w_adv) w_pc_nxt = w_pc_inc;
        end
        ST_IMM: begin
          w_ifid_instr = r_hold;
          w_ifid_imm   = imem_data;
          if (w_adv) begin
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = ST_FETCH;
          end
        end
        default: begin
          w_bubble = 1'b1;
          if (w_adv) begin
            w_pc_nxt    = imem_data;
            w_state_nxt = ST_FETCH;
          end
        end
      endcase
      // A frozen PC with a running IF/ID must not re-issue the same instruction.
      if (stall_F) w_bubble = 1'b1;
      if (w_bubble) begin
        w_ifid_instr = NOP;
        w_ifid_imm   = 8'h00;
        w_ifid_pc    = 8'h00;
      end
    end
  end

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .reset     (reset),
    .clear     (w_ifid_clear),
    .hold      (w_ifid_hold),
    .d_instr   (w_ifid_instr),
    .d_imm     (w_ifid_imm),
    .d_pc      (w_ifid_pc),
    .instr_id  (instr_id),
    .immediate (immediate),
    .pc_id     (pc_id)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Brief    : Directed self-checking bench for fetch_stage over a small program.
//  Revision : 1.0
// ============================================================================
module tb_fetch_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       stall_F;
  logic       stall_D;
  logic       flush_F;
  logic       branch_taken_ex;
  logic [7:0] branch_target;
  logic       intr_ack;
  logic [7:0] imem_data;
  logic [7:0] imem_addr;
  logic [7:0] instr_id;
  logic [7:0] immediate;
  logic [7:0] pc_id;

  logic [7:0] mem [256];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall_F         (stall_F),
    .stall_D         (stall_D),
    .flush_F         (flush_F),
    .branch_taken_ex (branch_taken_ex),
    .branch_target   (branch_target),
    .intr_ack        (intr_ack),
    .imem_data       (imem_data),
    .imem_addr       (imem_addr),
    .instr_id        (instr_id),
    .immediate       (immediate),
    .pc_id           (pc_id)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic check_ifid(input string tag, input logic [7:0] ins,
                            input logic [7:0] imm, input logic [7:0] pc);
    check({tag, "_instr"}, instr_id, ins);
    check({tag, "_imm"},   immediate, imm);
    check({tag, "_pc"},    pc_id, pc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h10;
    mem[8'h01] = 8'h80;
    mem[8'h10] = 8'h21;
    mem[8'h11] = 8'hC4;
    mem[8'h12] = 8'h5A;
    mem[8'h13] = 8'h33;
    mem[8'h14] = 8'hC7;
    mem[8'h15] = 8'h99;
    mem[8'h40] = 8'h47;
    mem[8'h41] = 8'h48;
    mem[8'h80] = 8'h81;
    mem[8'hFF] = 8'h55;

    reset = 1'b1; stall_F = 1'b0; stall_D = 1'b0; flush_F = 1'b0;
    branch_taken_ex = 1'b0; branch_target = 8'h00; intr_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr", imem_addr, 8'h00);
    check_ifid("rst", 8'h00, 8'h00, 8'h00);

    // Reset vector then first instruction
    reset = 1'b0;
    check("rstvec_addr", imem_addr, 8'h00);
    step();
    check("fetch0_addr", imem_addr, 8'h10);
    check("fetch0_instr", instr_id, 8'h00);
    step();
    check_ifid("first", 8'h21, 8'h00, 8'h11);
    check("first_addr", imem_addr, 8'h11);
    step();
    check_ifid("twobyte_bubble", 8'h00, 8'h00, 8'h00);
    check("imm_addr", imem_addr, 8'h12);
    step();
    check_ifid("twobyte", 8'hC4, 8'h5A, 8'h13);
    check("after_c4_addr", imem_addr, 8'h13);

    // Interrupt acceptance at PC=13
    intr_ack = 1'b1;
    step();
    intr_ack = 1'b0;
`ifdef FETCH_INTR_EN
    check_ifid("intr_ret", 8'h00, 8'h00, 8'h13);
    check("intvec_addr", imem_addr, 8'h01);
    step();
    check_ifid("intvec_nop", 8'h00, 8'h00, 8'h00);
    check("handler_addr", imem_addr, 8'h80);
    step();
    check_ifid("handler", 8'h81, 8'h00, 8'h81);
`else
    check_ifid("intr_ignored", 8'h33, 8'h00, 8'h14);
    check("no_vec_addr", imem_addr, 8'h14);
`endif

    // Redirect back to 13
    branch_taken_ex = 1'b1; branch_target = 8'h13;
    step();
    branch_taken_ex = 1'b0;
    check("br13_instr", instr_id, 8'h00);
    check("br13_addr", imem_addr, 8'h13);
    step();
    check_ifid("ret33", 8'h33, 8'h00, 8'h14);

    // Joint stall for 3 cycles
    stall_F = 1'b1; stall_D = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_addr", imem_addr, 8'h14);
      check_ifid("stall", 8'h33, 8'h00, 8'h14);
    end
    stall_F = 1'b0; stall_D = 1'b0;
    step();
    check("c7_bubble_instr", instr_id, 8'h00);
    check("c7_imm_addr", imem_addr, 8'h15);

    // Branch during IMM drops the held C7
    branch_taken_ex = 1'b1; branch_target = 8'h40;
    step();
    branch_taken_ex = 1'b0;
    check_ifid("br40_nop", 8'h00, 8'h00, 8'h00);
    check("br40_addr", imem_addr, 8'h40);
    step();
    check_ifid("tgt40", 8'h47, 8'h00, 8'h41);

    // Flush refetches the same instruction
    flush_F = 1'b1;
    step();
    flush_F = 1'b0;
    check_ifid("flush_nop", 8'h00, 8'h00, 8'h00);
    check("flush_addr", imem_addr, 8'h41);
    step();
    check_ifid("refetch", 8'h48, 8'h00, 8'h42);

    // PC wrap at FF
    branch_taken_ex = 1'b1; branch_target = 8'hFF;
    step();
    branch_taken_ex = 1'b0;
    check("brff_addr", imem_addr, 8'hFF);
    step();
    check_ifid("wrap", 8'h55, 8'h00, 8'h00);
    check("wrap_addr", imem_addr, 8'h00);
    step();
    check_ifid("after_wrap", 8'h10, 8'h00, 8'h01);

    // Async reset mid-cycle with live IF/ID contents
    branch_taken_ex = 1'b1; branch_target = 8'h10;
    step();
    branch_taken_ex = 1'b0;
    step();
    check_ifid("pre_rst", 8'h21, 8'h00, 8'h11);
    #2;
    reset = 1'b1;
    #1;
    check_ifid("async_rst", 8'h00, 8'h00, 8'h00);
    check("async_rst_addr", imem_addr, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    check("rerst_addr", imem_addr, 8'h10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
